// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and serial_add_ctrl.
// The ovf signal is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full_adder, one bit per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output bus.ovf.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic fsum,
    output logic fcarry
);
    assign fsum   = a ^ b ^ c;
    assign fcarry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cout_q;
    logic             fsum, fcarry;
    logic             accept, last_bit;
    logic             busy, done;

    full_adder u_fa (
        .a      (opa_q[0]),
        .b      (opb_q[0]),
        .c      (carry_q),
        .fsum   (fsum),
        .fcarry (fcarry)
    );

    assign accept   = (state_q == IDLE) && bus.start;
    assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            // Sum fills from the top so the LSB lands in bit 0 after WIDTH shifts.
            sum_q   <= {fsum, sum_q[WIDTH-1:1]};
            opa_q   <= opa_q >> 1;
            opb_q   <= opb_q >> 1;
            carry_q <= fcarry;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) cout_q <= fcarry;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the last bit carry_q is the carry into the MSB and fcarry the carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n)        ovf_q <= 1'b0;
        else if (last_bit) ovf_q <= carry_q ^ fcarry;
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: time-based reference model plus directed vectors.
// Define SERIAL_ADD_OVF_EN to also check the overflow output.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted add at edge k means busy in cycles k..k+W-1,
    // done in cycle k+W, and the next acceptance possible at edge k+W+2.
    int           edge_n = 0;
    int           acc    = -1;
    logic [W:0]   pending, shown;
    logic         pending_ovf, shown_ovf;

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            acc       = -1;
            shown     = '0;
            shown_ovf = 1'b0;
        end else begin
            if (acc >= 0 && edge_n == acc + W) begin
                shown     = pending;
                shown_ovf = pending_ovf;
            end
            if (bus.start && (acc < 0 || edge_n >= acc + W + 2)) begin
                acc         = edge_n;
                pending     = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
                pending_ovf = (bus.a[W-1] == bus.b[W-1]) && (pending[W-1] != bus.a[W-1]);
            end
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            automatic logic exp_busy = (acc >= 0) && (edge_n >= acc) && (edge_n < acc + W);
            automatic logic exp_done = (acc >= 0) && (edge_n == acc + W);
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("done", 32'(bus.done), 32'(exp_done));
            if (!exp_busy) begin
                check("sum", 32'(bus.sum), 32'(shown[W-1:0]));
                check("cout", 32'(bus.cout), 32'(shown[W]));
`ifdef SERIAL_ADD_OVF_EN
                check("ovf", 32'(bus.ovf), 32'(shown_ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!bus.done && cnt < 40) begin
            tick();
            cnt++;
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int cnt;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.cin   = tc;
        tick();
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_;
        bus.cin   = ~tc;
        wait_done(cnt);
        check("done_latency", 32'(cnt), 32'(W));
        check("lit_sum", 32'(bus.sum), 32'(es));
        check("lit_cout", 32'(bus.cout), 32'(ec));
        check("model_sum", 32'(shown), 32'({ec, es}));
`ifdef SERIAL_ADD_OVF_EN
        check("lit_ovf", 32'(bus.ovf), 32'(eo));
        check("model_ovf", 32'(shown_ovf), 32'(eo));
`else
        if (eo === 1'bx) check("ovf_arg", 32'(eo), 32'd0);
`endif
        tick();
    endtask

    initial begin
        int cnt;
        int dones;
        int t0, t1, t2;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        tick();

        do_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // A second request during RUN must be dropped, with no extra done pulse.
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.cin   = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'hAA;
        bus.cin   = 1'b1;
        tick();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                dones++;
                check("ign_sum", 32'(bus.sum), 32'h46);
                check("ign_cout", 32'(bus.cout), 32'd0);
            end
            tick();
        end
        check("ign_done_count", 32'(dones), 32'd1);

        // Reset in RUN cycle 4 discards the partial add.
        bus.start = 1'b1;
        bus.a     = 8'h33;
        bus.b     = 8'h44;
        bus.cin   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        tick();
        do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Start held high: one add every W+2 cycles.
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.cin   = 1'b0;
        t0 = -1;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (bus.done) begin
                check("b2b_sum", 32'(bus.sum), 32'h33);
                if (t0 < 0)      t0 = i;
                else if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        check("b2b_gap1", 32'(t1 - t0), 32'd10);
        check("b2b_gap2", 32'(t2 - t1), 32'd10);
        bus.start = 1'b0;
        cnt = 0;
        while ((bus.busy || bus.done) && cnt < 40) begin
            tick();
            cnt++;
        end
        check("b2b_drain", 32'(bus.busy | bus.done), 32'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
